// File: rtl/fifo_stream_reader.sv
// Drain-side adapter for the dual-clock FIFO read port: prefetches popped words into a
// 3-entry buffer and presents them as a valid/ready stream framed into fixed-length bursts.
module fifo_stream_reader #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned LEN_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic [LEN_WIDTH-1:0]  burst_len,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  input  logic                  fifo_empty,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  m_last,
  output logic                  busy,
  output logic [1:0]            level
);

  logic [DATA_WIDTH-1:0] mem_q [3];
  logic [1:0]            wr_ptr_q, wr_ptr_d;
  logic [1:0]            rd_ptr_q, rd_ptr_d;
  logic [1:0]            level_q, level_d;
  logic                  inflight_q;
  logic [LEN_WIDTH-1:0]  beat_cnt_q, beat_cnt_d;
  logic [LEN_WIDTH-1:0]  burst_len_q, burst_len_d;
  logic [2:0]            occupancy;
  logic                  capture;
  logic                  xfer;

  function automatic logic [1:0] ptr_inc(input logic [1:0] ptr);
    return (ptr == 2'd2) ? 2'd0 : ptr + 2'd1;
  endfunction

  // Count the in-flight word as occupied so a pop can never overrun the buffer.
  assign occupancy  = {1'b0, level_q} + {2'b00, inflight_q};
  assign fifo_rd_en = rst_n & enable & ~fifo_empty & (occupancy < 3'd3);

  assign capture = inflight_q;
  assign m_valid = (level_q != 2'd0);
  assign xfer    = m_valid & m_ready;
  assign m_data  = mem_q[rd_ptr_q];
  assign m_last  = m_valid & (burst_len_q != '0) &
                   (beat_cnt_q == burst_len_q - LEN_WIDTH'(1));
  assign busy    = m_valid | inflight_q;
  assign level   = level_q;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    level_d     = level_q;
    beat_cnt_d  = beat_cnt_q;
    burst_len_d = burst_len_q;

    if (capture) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (xfer)    rd_ptr_d = ptr_inc(rd_ptr_q);

    unique case ({capture, xfer})
      2'b10:   level_d = level_q + 2'd1;
      2'b01:   level_d = level_q - 2'd1;
      default: level_d = level_q;
    endcase

    // Burst length is only sampled between bursts so a change never splits a burst.
    if (beat_cnt_q == '0) burst_len_d = burst_len;

    if (xfer && (burst_len_q != '0)) begin
      beat_cnt_d = m_last ? '0 : beat_cnt_q + LEN_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q    <= 2'd0;
      rd_ptr_q    <= 2'd0;
      level_q     <= 2'd0;
      inflight_q  <= 1'b0;
      beat_cnt_q  <= '0;
      burst_len_q <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      inflight_q  <= fifo_rd_en;
      beat_cnt_q  <= beat_cnt_d;
      burst_len_q <= burst_len_d;
    end
  end

  // Storage is not reset; m_valid gates every read of it.
  always_ff @(posedge clk) begin
    if (rst_n && capture) mem_q[wr_ptr_q] <= fifo_rd_data;
  end

endmodule

// File: doc/fifo_stream_reader.md
Name: fifo_stream_reader

Overview:
Drain-side adapter for the dual-clock FIFO read port. It lives in the read clock domain and turns the FIFO's pop interface into a valid/ready stream. The pop interface is rd_en plus empty, with rd_data registered one cycle after a pop. The block prefetches into a 3-entry output buffer so the stream runs at full throughput with no combinational path from m_ready to fifo_rd_en. It also frames the stream into fixed-length bursts by generating m_last.

Parameters:
DATA_WIDTH, 8, width of FIFO data and stream data
LEN_WIDTH, 8, width of burst_len and of the internal beat counter

Ports:
clk  input  1  clock (FIFO read clock)
rst_n  input  1  synchronous reset, active low
enable  input  1  1 = new FIFO pops allowed; 0 = stop popping, buffered data still drains
burst_len  input  LEN_WIDTH  beats per burst; 0 = framing off, m_last never asserted
fifo_rd_en  output  1  pop request to the FIFO
fifo_rd_data  input  DATA_WIDTH  FIFO read data, valid the cycle after a pop
fifo_empty  input  1  FIFO empty flag
m_data  output  DATA_WIDTH  stream data (head of output buffer)
m_valid  output  1  stream valid
m_ready  input  1  stream ready
m_last  output  1  last beat of a burst, qualified by m_valid
busy  output  1  buffer or in-flight pop non-empty
level  output  2  output buffer occupancy, 0..3

Behaviour:
- Reset: all state is cleared on any clk edge with rst_n=0.
  - Reset values: m_valid=0, m_last=0, busy=0, level=0, in-flight flag=0, beat counter=0.
  - m_data is undefined until the first valid beat.
  - fifo_rd_en is forced 0 while rst_n=0.
- Pop rule: fifo_rd_en = rst_n & enable & ~fifo_empty & (level + inflight < 3).
  - inflight is a registered 1-bit flag, set the cycle after fifo_rd_en=1.
  - Every asserted pop therefore consumes exactly one FIFO word.
- Capture: when inflight=1, fifo_rd_data is written into the buffer tail at the end of that cycle.
- Latency: if fifo_rd_en=1 in cycle N, then
  - data is presented by the FIFO in cycle N+1 and captured at the end of N+1;
  - m_valid=1 in cycle N+2 if the buffer was empty.
- Buffer: 3-entry circular FIFO with 2-bit read and write pointers wrapping 2→0.
  - m_valid = (level != 0).
  - m_data = entry at the read pointer.
  - A beat transfers when m_valid & m_ready; the read pointer then advances.
  - Simultaneous capture and transfer: level unchanged, both pointers advance.
- Throughput: with the FIFO continuously non-empty and m_ready held at 1, steady state is one beat per cycle (level=1, inflight=1).
- Overflow: cannot occur under the pop rule. The bench asserts that capture never happens at level=3 without a same-cycle transfer.
- m_ready low: level fills to at most 3, then fifo_rd_en deasserts. m_data and m_last stay stable while m_valid=1 & m_ready=0.
- Framing:
  - burst_len_q is loaded from burst_len on every cycle the beat counter is 0; burst_len is ignored mid-burst.
  - m_last = m_valid & (burst_len_q != 0) & (beat_cnt == burst_len_q - 1).
  - On a transfer: if m_last=1, beat_cnt returns to 0; otherwise it increments.
  - burst_len_q=1: every beat is last.
  - burst_len_q=0: beat_cnt stays 0 and m_last stays 0.
- enable deassert: takes effect in the same cycle (no new pops). An in-flight word is still captured, and the buffer drains normally.
- fifo_empty rising while a pop is in flight: the in-flight word is still captured; no further pops are issued.
- Reset mid-operation: buffered and in-flight data are discarded, with no partial burst carry-over. The FIFO must be reset together with this block.
- busy = (level != 0) | inflight.

Test Plan:
- Latency: reset, preload FIFO with 0x11, release rst_n, enable=1, m_ready=1 → fifo_rd_en in cycle N, m_valid=1 with m_data=0x11 in cycle N+2, one beat only.
- Throughput: 16 words 0x00..0x0F, m_ready=1, burst_len=0 → 16 consecutive m_valid cycles, data in order, m_last never 1.
- Backpressure: 8 words, m_ready=0 for 10 cycles, then 1 → level saturates at 3 and fifo_rd_en stops after 3 pops. m_data=0x00 is held stable, then 8 beats arrive in order with no loss or duplication.
- Framing: burst_len=4, 12 words, m_ready toggled randomly → m_last on beats 3, 7, 11 only. burst_len is changed to 2 mid-burst and takes effect only after the current last.
- Boundary: burst_len=1 → m_last on every beat. enable dropped with a pop in flight → that word is still delivered, then no further pops while the FIFO is non-empty.
- Reset mid-stream: assert rst_n=0 with level=2 and inflight=1 → the next cycle shows m_valid=0, level=0, busy=0, fifo_rd_en=0, and beat_cnt restarts at 0 after release.
